// File: rtl/hyst_cmp_array.sv
// Multi-channel hysteresis comparator with per-channel debounce and toggle pulse.
// Each channel flips between A_LE and A_GT once the active condition holds for DB edges.
module hyst_cmp_array #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CH    = 4,
    parameter int unsigned TH_W  = 4,
    parameter int unsigned DB    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  sclr,
    input  logic [TH_W-1:0]       th,
    input  logic [CH*WIDTH-1:0]   a_bus,
    input  logic [CH*WIDTH-1:0]   b_bus,
    output logic [CH-1:0]         out,
    output logic [CH-1:0]         chg
);

    localparam int unsigned CNT_W = (DB > 1) ? $clog2(DB + 1) : 1;
    // One spare bit above the wider operand so a+th and b+th never wrap
    localparam int unsigned CMP_W = ((WIDTH > TH_W) ? WIDTH : TH_W) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB - 1);

    typedef enum logic {
        A_LE = 1'b0,
        A_GT = 1'b1
    } state_t;

    logic [CMP_W-1:0] th_x;
    assign th_x = CMP_W'(th);

    for (genvar g = 0; g < CH; g++) begin : g_ch
        logic [CMP_W-1:0] a_x;
        logic [CMP_W-1:0] b_x;
        logic             valid_c;
        logic             rise_c;
        logic             fall_c;
        logic             act_c;
        state_t           state;
        logic [CNT_W-1:0] cnt;

        assign a_x     = CMP_W'(a_bus[g*WIDTH +: WIDTH]);
        assign b_x     = CMP_W'(b_bus[g*WIDTH +: WIDTH]);
        assign valid_c = (a_x != '0) && (b_x != '0);
        assign rise_c  = valid_c && (a_x > (b_x + th_x));
        assign fall_c  = valid_c && (b_x > (a_x + th_x));
        assign act_c   = (state == A_LE) ? rise_c : fall_c;

        // Per-channel state, debounce counter and change pulse
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state  <= A_LE;
                cnt    <= '0;
                chg[g] <= 1'b0;
            end else if (sclr) begin
                state  <= A_LE;
                cnt    <= '0;
                chg[g] <= 1'b0;
            end else if (!en) begin
                cnt    <= '0;
                chg[g] <= 1'b0;
            end else begin
                chg[g] <= 1'b0;
                if (!act_c) begin
                    cnt <= '0;
                end else if (cnt == CNT_LAST) begin
                    state  <= (state == A_LE) ? A_GT : A_LE;
                    cnt    <= '0;
                    chg[g] <= 1'b1;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end

        assign out[g] = (state == A_GT);
    end

endmodule

// File: tb/tb_hyst_cmp_array.sv
// Directed table-driven bench for hyst_cmp_array (WIDTH=8, CH=4, TH_W=4, DB=2).
module tb_hyst_cmp_array;

    logic        clk;
    logic        rst;
    logic        en;
    logic        sclr;
    logic [3:0]  th;
    logic [31:0] a_bus;
    logic [31:0] b_bus;
    logic [3:0]  out;
    logic [3:0]  chg;

    int n_vec;
    int n_bad;

    typedef struct {
        logic        en;
        logic        sclr;
        logic [3:0]  th;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  out;
        logic [3:0]  chg;
    } vec_t;

    vec_t vecs[$];

    hyst_cmp_array #(.WIDTH(8), .CH(4), .TH_W(4), .DB(2)) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .sclr  (sclr),
        .th    (th),
        .a_bus (a_bus),
        .b_bus (b_bus),
        .out   (out),
        .chg   (chg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] p(input int c3, input int c2, input int c1, input int c0);
        return {8'(c3), 8'(c2), 8'(c1), 8'(c0)};
    endfunction

    function automatic void add(input logic e, input logic s, input int t,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [3:0] o, input logic [3:0] c);
        vec_t v;
        v.en = e; v.sclr = s; v.th = 4'(t); v.a = a; v.b = b; v.out = o; v.chg = c;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic apply(input int i);
        @(negedge clk);
        en    = vecs[i].en;
        sclr  = vecs[i].sclr;
        th    = vecs[i].th;
        a_bus = vecs[i].a;
        b_bus = vecs[i].b;
        @(posedge clk);
        #1;
        check($sformatf("v%0d.out", i), out, vecs[i].out);
        check($sformatf("v%0d.chg", i), chg, vecs[i].chg);
    endtask

    localparam int SPLIT = 24;

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst = 1'b0; en = 1'b0; sclr = 1'b0; th = '0; a_bus = '0; b_bus = '0;

        // ch0 rise/fall with th=10
        add(1, 0, 10, p(0,0,0,100), p(0,0,0,80),  4'b0000, 4'b0000);
        add(1, 0, 10, p(0,0,0,100), p(0,0,0,80),  4'b0001, 4'b0001);
        add(1, 0, 10, p(0,0,0,100), p(0,0,0,80),  4'b0001, 4'b0000);
        add(1, 0, 10, p(0,0,0,85),  p(0,0,0,90),  4'b0001, 4'b0000);
        add(1, 0, 10, p(0,0,0,85),  p(0,0,0,90),  4'b0001, 4'b0000);
        add(1, 0, 10, p(0,0,0,85),  p(0,0,0,100), 4'b0001, 4'b0000);
        add(1, 0, 10, p(0,0,0,85),  p(0,0,0,100), 4'b0000, 4'b0001);
        add(1, 0, 10, p(0,0,0,85),  p(0,0,0,100), 4'b0000, 4'b0000);
        // ch1 glitch, th=5
        add(1, 0, 5,  p(0,0,50,0),  p(0,0,40,0),  4'b0000, 4'b0000);
        add(1, 0, 5,  p(0,0,40,0),  p(0,0,40,0),  4'b0000, 4'b0000);
        add(1, 0, 5,  p(0,0,50,0),  p(0,0,40,0),  4'b0000, 4'b0000);
        add(1, 0, 5,  p(0,0,50,0),  p(0,0,40,0),  4'b0010, 4'b0010);
        add(1, 0, 5,  p(0,0,0,0),   p(0,0,0,0),   4'b0010, 4'b0000);
        // ch2 overflow-safe compare, th=15
        add(1, 0, 15, p(0,255,0,0), p(0,250,0,0), 4'b0010, 4'b0000);
        add(1, 0, 15, p(0,255,0,0), p(0,250,0,0), 4'b0010, 4'b0000);
        add(1, 0, 15, p(0,200,0,0), p(0,10,0,0),  4'b0010, 4'b0000);
        add(1, 0, 15, p(0,200,0,0), p(0,10,0,0),  4'b0110, 4'b0100);
        add(1, 0, 15, p(0,3,0,0),   p(0,250,0,0), 4'b0110, 4'b0000);
        add(1, 0, 15, p(0,3,0,0),   p(0,250,0,0), 4'b0010, 4'b0100);
        // ch1 in A_GT with a=0 holds
        add(1, 0, 15, p(0,0,0,0),   p(0,0,200,0), 4'b0010, 4'b0000);
        add(1, 0, 15, p(0,0,0,0),   p(0,0,200,0), 4'b0010, 4'b0000);
        add(1, 0, 15, p(0,0,0,0),   p(0,0,200,0), 4'b0010, 4'b0000);
        // ch0 and ch3 together; ch2 starts a count that reset must discard
        add(1, 0, 0,  p(9,0,0,5),   p(1,0,200,4), 4'b0010, 4'b0000);
        add(1, 0, 0,  p(9,10,0,5),  p(1,1,200,4), 4'b1011, 4'b1001);
        // after reset: ch2 count starts from zero
        add(1, 0, 0,  p(0,10,0,0),  p(0,1,0,0),   4'b0000, 4'b0000);
        add(1, 0, 0,  p(0,10,0,0),  p(0,1,0,0),   4'b0100, 4'b0100);
        // en=0 mid-debounce restarts the count
        add(1, 0, 0,  p(0,0,0,5),   p(0,0,0,4),   4'b0100, 4'b0000);
        add(0, 0, 0,  p(0,0,0,5),   p(0,0,0,4),   4'b0100, 4'b0000);
        add(1, 0, 0,  p(0,0,0,5),   p(0,0,0,4),   4'b0100, 4'b0000);
        add(1, 0, 0,  p(0,0,0,5),   p(0,0,0,4),   4'b0101, 4'b0001);
        // sclr beats a pending toggle and en
        add(1, 0, 0,  p(9,0,0,5),   p(1,0,0,4),   4'b0101, 4'b0000);
        add(1, 1, 0,  p(9,0,0,5),   p(1,0,0,4),   4'b0000, 4'b0000);
        add(1, 0, 0,  p(9,0,0,5),   p(1,0,0,4),   4'b0000, 4'b0000);
        add(1, 0, 0,  p(9,0,0,5),   p(1,0,0,4),   4'b1001, 4'b1001);
        add(0, 1, 0,  p(9,0,0,5),   p(1,0,0,4),   4'b0000, 4'b0000);

        #2;
        check("reset.out", out, 4'b0000);
        check("reset.chg", chg, 4'b0000);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < SPLIT; i++) apply(i);

        // Asynchronous reset mid-cycle while out=1011, chg=1001
        #2;
        rst = 1'b0;
        #1;
        check("async_rst.out", out, 4'b0000);
        check("async_rst.chg", chg, 4'b0000);
        en = 1'b0; a_bus = '0; b_bus = '0;
        @(negedge clk);
        rst = 1'b1;

        for (int i = SPLIT; i < vecs.size(); i++) apply(i);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
